// File: rtl/tm1638_pkg.sv
// tm1638_pkg: TM1638 command bytes, scheduler states and key-scan decode.
package tm1638_pkg;
  localparam logic [7:0] CMD_WRITE_AUTO = 8'h40;
  localparam logic [7:0] CMD_READ_KEYS = 8'h42;
  localparam logic [7:0] CMD_ADDR0 = 8'h C0;
  localparam logic [7:0] CMD_CTRL_BASE = 8'h80;
  typedef enum logic [2:0] {S_IDLE, S_MODE, S_ADDR, S_DATA, S_CTRL, S_RCMD, S_READ, S_KEYS} state_t;
  // scan byte j carries key j in bit0 and key j+4 in bit4
  function automatic logic [7:0] key_bits(input logic [7:0] b, input logic [1:0] j);
    logic [7:0] k;
    k = '0;
    k[{1'b0, j}] = b[0];
    k[{1'b1, j}] = b[4];
    return k;
  endfunction
endpackage

// File: rtl/tm1638_frame_scheduler.sv
// tm1638_frame_scheduler: sequences TM1638 write/ctrl/key-scan frames onto a byte engine.
// TM1638_FRAME_SCHED_DIRTY_EN: skip the write part of a frame whose snapshot is unchanged.
module tm1638_frame_scheduler #(
  parameter int KEY_BYTES = 4,
  parameter int DIGITS = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                frame_tick,
  input  logic                display_off,
  input  logic [2:0]          display_level,
  input  logic [8*DIGITS-1:0] seg_data,
  input  logic [DIGITS-1:0]   leds_green,
  input  logic [DIGITS-1:0]   leds_red,
  output logic                byte_valid,
  input  logic                byte_ready,
  output logic [7:0]          byte_data,
  output logic                byte_read,
  output logic                byte_last,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  output logic [7:0]          keys,
  output logic                keys_valid,
  output logic                busy
);
  import tm1638_pkg::*;
  localparam int NB = 2 * DIGITS;
  localparam int IW = $clog2(NB);
  localparam int RW = KEY_BYTES > 1 ? $clog2(KEY_BYTES) : 1;
  localparam int CW = $clog2(KEY_BYTES + 1);
  localparam int SW = 8 * DIGITS + 2 * DIGITS + 4;
  state_t state;
  logic pending, req_done;
  logic [SW-1:0] snap, snap_in;
  logic [IW-1:0] idx, sel;
  logic [IW-2:0] pos;
  logic [RW-1:0] rd_cnt;
  logic [CW-1:0] rx_cnt;
  logic [7:0] keys_acc, key_next, data_sel, ctrl_byte;
  logic [8*DIGITS-1:0] seg_s, seg_sh;
  logic [DIGITS-1:0] red_s, green_s;
  logic off_s, xfer, rd_last, rx_take, reqs_done, rx_done, skip;
  logic [2:0] lvl_s;
`ifdef TM1638_FRAME_SCHED_DIRTY_EN
  logic have_prev;
  assign skip = have_prev && snap_in == snap;
`else
  assign skip = 1'b0;
`endif
  assign snap_in = {seg_data, leds_red, leds_green, display_off, display_level};
  assign seg_s = snap[SW-1 -: 8*DIGITS];
  assign red_s = snap[2*DIGITS+3 -: DIGITS];
  assign green_s = snap[DIGITS+3 -: DIGITS];
  assign off_s = snap[3];
  assign lvl_s = snap[2:0];
  assign ctrl_byte = CMD_CTRL_BASE | {4'b0, ~off_s, lvl_s};
  // sel is the display address of the byte loaded on the next DATA transfer
  assign sel = (state == S_ADDR) ? '0 : idx + 1'b1;
  assign pos = sel[IW-1:1];
  assign seg_sh = seg_s >> {pos, 3'b000};
  assign data_sel = sel[0] ? {6'b0, red_s[pos], green_s[pos]} : seg_sh[7:0];
  assign xfer = byte_valid && byte_ready;
  assign rd_last = rd_cnt == RW'(KEY_BYTES - 1);
  assign rx_take = state == S_READ && rx_valid && rx_cnt != CW'(KEY_BYTES);
  assign key_next = (rx_take && 32'(rx_cnt) < 4) ? keys_acc | key_bits(rx_data, 2'(rx_cnt)) : keys_acc;
  assign reqs_done = req_done || (xfer && rd_last);
  assign rx_done = rx_cnt == CW'(KEY_BYTES) || (rx_take && rx_cnt == CW'(KEY_BYTES - 1));
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state <= S_IDLE;
      pending <= 1'b0;
      snap <= '0;
      idx <= '0;
      rd_cnt <= '0;
      rx_cnt <= '0;
      req_done <= 1'b0;
      keys_acc <= '0;
      byte_valid <= 1'b0;
      byte_data <= '0;
      byte_read <= 1'b0;
      byte_last <= 1'b0;
      keys <= '0;
      keys_valid <= 1'b0;
      busy <= 1'b0;
`ifdef TM1638_FRAME_SCHED_DIRTY_EN
      have_prev <= 1'b0;
`endif
    end else begin
      keys_valid <= 1'b0;
      if (frame_tick && state != S_IDLE) pending <= 1'b1;
      if (rx_take) begin
        rx_cnt <= rx_cnt + 1'b1;
        keys_acc <= key_next;
      end
      case (state)
        S_IDLE: if (frame_tick || pending) begin
          snap <= snap_in;
          busy <= 1'b1;
          pending <= 1'b0;
          idx <= '0;
          rd_cnt <= '0;
          rx_cnt <= '0;
          req_done <= 1'b0;
          keys_acc <= '0;
          byte_valid <= 1'b1;
          byte_read <= 1'b0;
          state <= skip ? S_RCMD : S_MODE;
          byte_data <= skip ? CMD_READ_KEYS : CMD_WRITE_AUTO;
          byte_last <= !skip;
`ifdef TM1638_FRAME_SCHED_DIRTY_EN
          have_prev <= 1'b1;
`endif
        end
        S_MODE: if (xfer) begin
          state <= S_ADDR;
          byte_data <= CMD_ADDR0;
          byte_last <= 1'b0;
        end
        S_ADDR: if (xfer) begin
          state <= S_DATA;
          idx <= '0;
          byte_data <= data_sel;
          byte_last <= 1'b0;
        end
        S_DATA: if (xfer) begin
          if (idx == IW'(NB - 1)) begin
            state <= S_CTRL;
            byte_data <= ctrl_byte;
            byte_last <= 1'b1;
          end else begin
            idx <= sel;
            byte_data <= data_sel;
            byte_last <= idx == IW'(NB - 2);
          end
        end
        S_CTRL: if (xfer) begin
          state <= S_RCMD;
          byte_data <= CMD_READ_KEYS;
          byte_last <= 1'b0;
        end
        S_RCMD: if (xfer) begin
          state <= S_READ;
          byte_read <= 1'b1;
          byte_data <= '0;
          byte_last <= KEY_BYTES == 1;
        end
        S_READ: begin
          if (xfer) begin
            if (rd_last) begin
              byte_valid <= 1'b0;
              byte_read <= 1'b0;
              byte_last <= 1'b0;
              req_done <= 1'b1;
            end else begin
              rd_cnt <= rd_cnt + 1'b1;
              byte_last <= rd_cnt == RW'(KEY_BYTES - 2);
            end
          end
          // both the requests and the received bytes must be complete
          if (reqs_done && rx_done) begin
            state <= S_KEYS;
            keys <= key_next;
            keys_valid <= 1'b1;
          end
        end
        S_KEYS: begin
          state <= S_IDLE;
          busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_tm1638_frame_scheduler.sv
// tb_tm1638_frame_scheduler: scoreboard bench with a behavioural byte engine.
module tb_tm1638_frame_scheduler;
  localparam int D = 8;
  localparam int KB = 4;
  logic clk = 0, n_rst = 0, frame_tick = 0, display_off = 0;
  logic [2:0] display_level = '0;
  logic [8*D-1:0] seg_data = '0;
  logic [D-1:0] leds_green = '0, leds_red = '0;
  logic byte_ready = 0, rx_valid = 0;
  logic [7:0] rx_data = '0;
  logic byte_valid, byte_read, byte_last, keys_valid, busy;
  logic [7:0] byte_data, keys;

  tm1638_frame_scheduler #(.KEY_BYTES(KB), .DIGITS(D)) dut (
    .clk(clk), .n_rst(n_rst), .frame_tick(frame_tick), .display_off(display_off),
    .display_level(display_level), .seg_data(seg_data), .leds_green(leds_green),
    .leds_red(leds_red), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .byte_data(byte_data), .byte_read(byte_read), .byte_last(byte_last),
    .rx_valid(rx_valid), .rx_data(rx_data), .keys(keys), .keys_valid(keys_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  logic [10:0] exp_q[$];
  logic [7:0] key_src[$], rx_sched[$], keys_q[$];
  logic bp = 0, stall_prev = 0;
  int hold = 0, xfers = 0;
  logic [9:0] stall_val = '0;
  logic [10:0] e;
`ifdef TM1638_FRAME_SCHED_DIRTY_EN
  logic have_prev_m = 0;
  logic [8*D+2*D+3:0] prev_m = '0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // entry layout: {valid, read, last, data}; data is don't-care for reads
  task automatic start_frame(input logic [7:0] b0, b1, b2, b3);
    logic [7:0] kb[4];
    logic [7:0] kk;
    logic full;
    kb = '{b0, b1, b2, b3};
    kk = '0;
    full = 1'b1;
`ifdef TM1638_FRAME_SCHED_DIRTY_EN
    full = !(have_prev_m && prev_m == {seg_data, leds_red, leds_green, display_off, display_level});
    have_prev_m = 1'b1;
    prev_m = {seg_data, leds_red, leds_green, display_off, display_level};
`endif
    if (full) begin
      exp_q.push_back({3'b101, 8'h40});
      exp_q.push_back({3'b100, 8'hC0});
      for (int i = 0; i < D; i++) begin
        exp_q.push_back({3'b100, seg_data[8*i +: 8]});
        exp_q.push_back({2'b10, i == D - 1, 6'b0, leds_red[i], leds_green[i]});
      end
      exp_q.push_back({3'b101, 8'h80 | (display_off ? 8'h00 : 8'h08) | {5'b0, display_level}});
    end
    exp_q.push_back({3'b100, 8'h42});
    for (int j = 0; j < KB; j++) begin
      exp_q.push_back({2'b11, j == KB - 1, 8'h00});
      key_src.push_back(kb[j]);
      kk[j] = kb[j][0];
      kk[j+4] = kb[j][4];
    end
    keys_q.push_back(kk);
  endtask

  task automatic tick(input bit lat);
    frame_tick = 1;
    @(negedge clk);
    frame_tick = 0;
    if (lat) begin
      chk("first_valid", 32'(byte_valid), 32'd1);
      chk("first_busy", 32'(busy), 32'd1);
    end
  endtask

  task automatic wait_frame_end(input bit tick_keys, input logic [31:0] nb);
    int t = 0;
    while (!keys_valid && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("keys_valid_seen", 32'(keys_valid), 32'd1);
    chk("keys", 32'(keys), 32'(keys_q.size() != 0 ? keys_q.pop_front() : 8'h00));
    chk("busy_at_keys", 32'(busy), 32'd1);
    if (tick_keys) begin
      frame_tick = 1;
      start_frame(nb[7:0], nb[15:8], nb[23:16], nb[31:24]);
    end
    @(negedge clk);
    frame_tick = 0;
    chk("keys_valid_pulse", 32'(keys_valid), 32'd0);
    chk("busy_fall", 32'(busy), 32'd0);
  endtask

  // byte engine: ready policy, transfer scoreboard, and rx byte scheduling
  initial forever begin
    @(negedge clk);
    if (!n_rst) begin
      stall_prev = 0;
      hold = 0;
      byte_ready = 0;
    end else if (byte_valid) begin
      if (stall_prev) chk("stable", 32'({byte_read, byte_last, byte_data}), 32'(stall_val));
      if (bp && hold < 5) begin
        byte_ready = 0;
        hold++;
        stall_prev = 1;
        stall_val = {byte_read, byte_last, byte_data};
      end else begin
        e = exp_q.size() != 0 ? exp_q.pop_front() : 11'h0;
        chk($sformatf("byte%0d", xfers), 32'({1'b1, byte_read, byte_last, e[9] ? e[7:0] : byte_data}), 32'(e));
        byte_ready = 1;
        hold = 0;
        stall_prev = 0;
        xfers++;
        if (byte_read && key_src.size() != 0) rx_sched.push_back(key_src.pop_front());
      end
    end else begin
      if (stall_prev) chk("valid_held", 32'(byte_valid), 32'd1);
      stall_prev = 0;
      byte_ready = !bp;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rx_sched.size() != 0) begin
      rx_valid = 1;
      rx_data = rx_sched.pop_front();
    end else begin
      rx_valid = 0;
      rx_data = 8'h00;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0, t;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({byte_valid, byte_data, byte_read, byte_last, keys, keys_valid, busy}), 32'd0);
    n_rst = 1;
    @(negedge clk);
    for (int i = 0; i < D; i++) seg_data[8*i +: 8] = 8'h10 + 8'(i);
    seg_data[7:0] = 8'h06;
    seg_data[63:56] = 8'h7F;
    leds_green = 8'h01;
    leds_red = 8'h02;
    display_level = 3'd4;
    start_frame(8'h01, 8'h10, 8'h00, 8'h11);
    tick(1);
    wait_frame_end(0, 32'h0);
    rx_sched.push_back(8'hFF);
    rx_sched.push_back(8'hFF);
    repeat (4) @(negedge clk);
    bp = 1;
    seg_data = {$urandom, $urandom};
    leds_green = 8'($urandom);
    leds_red = 8'($urandom);
    display_off = 1;
    display_level = 3'd6;
    start_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    tick(1);
    wait_frame_end(0, 32'h0);
    bp = 0;
    display_off = 0;
    start_frame(8'h11, 8'h11, 8'h11, 8'h11);
    tick(1);
    repeat (3) @(negedge clk);
    seg_data[15:8] = 8'h5A;
    display_level = 3'd7;
    start_frame(8'h00, 8'h01, 8'h10, 8'h00);
    tick(0);
    repeat (5) @(negedge clk);
    tick(0);
    repeat (7) @(negedge clk);
    tick(0);
    wait_frame_end(0, 32'h0);
    @(negedge clk);
    chk("pending_start", 32'({byte_valid, byte_data}), 32'({1'b1, 8'h40}));
    wait_frame_end(0, 32'h0);
    repeat (20) @(negedge clk);
    chk("no_extra_frame", 32'(busy), 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    start_frame(8'h10, 8'h01, 8'h10, 8'h01);
    tick(1);
    wait_frame_end(1, 32'h11_00_00_01);
    wait_frame_end(0, 32'h0);
    seg_data[7:0] = 8'h3C;
    x0 = xfers;
    start_frame(8'h01, 8'h01, 8'h01, 8'h01);
    tick(1);
    t = 0;
    while (xfers < x0 + 6 && t < 200) begin
      @(negedge clk);
      t++;
    end
    #2 n_rst = 0;
    #1 chk("async_reset", 32'({byte_valid, byte_data, byte_read, byte_last, keys, keys_valid, busy}), 32'd0);
    exp_q.delete();
    key_src.delete();
    rx_sched.delete();
    keys_q.delete();
`ifdef TM1638_FRAME_SCHED_DIRTY_EN
    have_prev_m = 0;
`endif
    repeat (2) @(negedge clk);
    n_rst = 1;
    @(negedge clk);
    start_frame(8'h00, 8'h10, 8'h01, 8'h00);
    tick(1);
    wait_frame_end(0, 32'h0);
    start_frame(8'h11, 8'h00, 8'h00, 8'h10);
    tick(1);
    wait_frame_end(0, 32'h0);
    display_level = 3'd2;
    start_frame(8'h01, 8'h00, 8'h10, 8'h01);
    tick(1);
    wait_frame_end(0, 32'h0);
    repeat (4) @(negedge clk);
    chk("final_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
